// File: rtl/fetch_lsu_pkg.sv
// Shared types for the fetch / load-store sequencer: command opcodes,
// FSM state encoding and the legal RAM latency range.
package fetch_lsu_pkg;

  // Command opcodes presented by the controller FSM
  typedef enum logic [1:0] {
    OP_FETCH  = 2'd0,
    OP_LOAD   = 2'd1,
    OP_STORE  = 2'd2,
    OP_BRANCH = 2'd3
  } op_e;

  // Sequencer states
  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_BR      = 3'd4
  } state_e;

  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 7;

  // Width of a down-counter that must hold the value lat
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/fetch_lsu_mem_lat_timer.sv
// Loadable down-counter that measures the fixed RAM read latency.
// load presets the count to RAM_LAT; en counts down, saturating at zero.
// expired is high whenever the count has reached zero.
module mem_lat_timer
  import fetch_lsu_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = cnt_width(RAM_LAT);

  logic [CNT_W-1:0] r_cnt;

  // Preset on load, otherwise count down while enabled and not yet zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= CNT_W'(RAM_LAT);
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/fetch_lsu.sv
// Instruction-fetch / load-store sequencer. Owns PC, IR, the RAM address
// and write-data registers and the load-data register; serves one command
// at a time over a valid/ready handshake and drives a synchronous RAM
// whose read data appears RAM_LAT edges after it samples the address.
module fetch_lsu
  import fetch_lsu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_en,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data
);

  // Reject unsupported read latencies at elaboration time
  generate
    if ((RAM_LAT < RAM_LAT_MIN) || (RAM_LAT > RAM_LAT_MAX)) begin : g_bad_ram_lat
      $error("fetch_lsu: RAM_LAT must lie in 1..7");
    end
  endgenerate

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_ld_data;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_w_en;
  logic [DATA_W-1:0] r_ram_w_data;
  logic              r_done;
  logic              r_is_fetch;   // outstanding read targets IR (1) or ld_data (0)

  op_e               w_op;
  logic              w_accept;
  logic              w_is_read;
  logic              w_tmr_load;
  logic              w_tmr_en;
  logic              w_expired;

  assign w_op       = op_e'(cmd_op);
  assign cmd_ready  = (r_state == S_IDLE);
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_is_read  = (w_op == OP_FETCH) | (w_op == OP_LOAD);
  assign w_tmr_load = w_accept & w_is_read;
  assign w_tmr_en   = (r_state == S_RD_WAIT);

  mem_lat_timer #(
    .RAM_LAT (RAM_LAT)
  ) u_lat_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_tmr_load),
    .en      (w_tmr_en),
    .expired (w_expired)
  );

  // Sequencer FSM with its register file; all outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_INIT;
      r_pc         <= '0;
      r_ir         <= '0;
      r_ld_data    <= '0;
      r_ram_addr   <= '0;
      r_ram_w_en   <= 1'b0;
      r_ram_w_data <= '0;
      r_done       <= 1'b0;
      r_is_fetch   <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_pc       <= start_pc;
          r_done     <= 1'b0;
          r_ram_w_en <= 1'b0;
          r_state    <= S_IDLE;
        end

        S_IDLE: begin
          // done is a single pulse: the completion cycle is the first IDLE cycle
          r_done <= 1'b0;
          if (w_accept) begin
            case (w_op)
              OP_FETCH: begin
                r_ram_addr <= r_pc;
                r_is_fetch <= 1'b1;
                r_state    <= S_RD_WAIT;
              end
              OP_LOAD: begin
                r_ram_addr <= cmd_addr;
                r_is_fetch <= 1'b0;
                r_state    <= S_RD_WAIT;
              end
              OP_STORE: begin
                r_ram_addr   <= cmd_addr;
                r_ram_w_data <= cmd_wdata;
                r_ram_w_en   <= 1'b1;
                r_state      <= S_WR;
              end
              OP_BRANCH: begin
                r_pc    <= cmd_addr;
                r_state <= S_BR;
              end
              default: begin
                r_state <= S_IDLE;
              end
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_RD_WAIT: begin
          // The timer reaches zero on the edge the RAM data becomes valid;
          // the data is captured on the following edge.
          if (w_expired) begin
            if (r_is_fetch) begin
              r_ir <= ram_r_data;
              r_pc <= r_pc + ADDR_W'(1);
            end else begin
              r_ld_data <= ram_r_data;
            end
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RD_WAIT;
          end
        end

        S_WR: begin
          // The RAM performs the write on this edge; strobe lasts one cycle
          r_ram_w_en <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= S_IDLE;
        end

        S_BR: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_ram_w_en <= 1'b0;
          r_done     <= 1'b0;
          r_state    <= S_INIT;
        end
      endcase
    end
  end

  assign pc         = r_pc;
  assign ir         = r_ir;
  assign ld_data    = r_ld_data;
  assign ram_addr   = r_ram_addr;
  assign ram_w_en   = r_ram_w_en;
  assign ram_w_data = r_ram_w_data;
  assign done       = r_done;

endmodule

// File: doc/fetch_lsu.md
Name: fetch_lsu

Overview:
Parametrised instruction-fetch / load-store sequencer for the lab CPU. It owns the program counter, instruction register, memory address register and load-data register. It serves one command at a time from the controller FSM over a valid/ready handshake, and drives a synchronous single-port RAM with configurable fixed read latency. It generalises the fixed 8-bit, single-cycle PC/IR/address mux arrangement: widths are parametrised, RAM latency is parametrised, and branch (PC load) and completion signalling are added.

Parameters:
ADDR_W, 8, width of PC and RAM address
DATA_W, 16, width of instruction/data words
RAM_LAT, 1, RAM read latency in clock edges from address sampled to data valid; legal range is 1..7

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
start_pc  input  ADDR_W  PC value loaded on leaving INIT
cmd_valid  input  1  controller presents a command
cmd_ready  output  1  block accepts a command this cycle
cmd_op  input  2  0=FETCH, 1=LOAD, 2=STORE, 3=BRANCH
cmd_addr  input  ADDR_W  data address (LOAD/STORE) or branch target (BRANCH)
cmd_wdata  input  DATA_W  store data (STORE)
done  output  1  one-cycle pulse: command completed, results visible
pc  output  ADDR_W  current program counter
ir  output  DATA_W  instruction register
ld_data  output  DATA_W  last loaded data word
ram_addr  output  ADDR_W  registered RAM address
ram_w_en  output  1  registered RAM write enable
ram_w_data  output  DATA_W  registered RAM write data
ram_r_data  input  DATA_W  RAM read data

Behaviour:
- Reset (async, rst_n=0): all outputs 0 (pc, ir, ld_data, ram_addr, ram_w_en, ram_w_data, cmd_ready, done); state=INIT. Reset mid-command aborts it: ram_w_en drops immediately and no done is issued.
- States: INIT, IDLE, RD_WAIT, WR, BR.
- INIT: lasts 1 cycle after reset release; pc<=start_pc; then IDLE. cmd_ready=0.
- IDLE: cmd_ready=1 (combinational from state). Accept = cmd_valid & cmd_ready at edge E0.
  - FETCH: ram_addr<=pc; cnt<=RAM_LAT; ->RD_WAIT.
  - LOAD: ram_addr<=cmd_addr; cnt<=RAM_LAT; ->RD_WAIT.
  - STORE: ram_addr<=cmd_addr; ram_w_data<=cmd_wdata; ram_w_en<=1; ->WR.
  - BRANCH: pc<=cmd_addr; ->BR.
- RD_WAIT: decrement cnt each edge. At edge E0+RAM_LAT+1, capture ram_r_data into ir (FETCH, also pc<=pc+1) or into ld_data (LOAD); done<=1; ->IDLE.
- WR: RAM writes at E1; at E1 ram_w_en<=0, done<=1; ->IDLE.
- BR: at E1 done<=1; ->IDLE.
- done is high exactly in the first IDLE cycle after completion. cmd_ready is also high in that cycle, so a new command may be accepted there (back-to-back, no bubble).
- cmd_op, cmd_addr and cmd_wdata are sampled only at accept; changes afterwards are ignored. cmd_valid while not ready is held off, never dropped.
- PC increment is modulo 2^ADDR_W: pc=all-ones wraps to 0.
- ram_addr and ram_w_data hold their values between commands. ram_w_en is high only in the WR cycle.
- Latency from accept to done: FETCH/LOAD = RAM_LAT+1 cycles; STORE = 1 cycle; BRANCH = 1 cycle.
- cnt width is $clog2(RAM_LAT+1).
- A RAM_LAT outside 1..7 is an elaboration error (static assertion).

Decomposition:
- Package fetch_lsu_pkg holds:
  - the cmd_op enum (OP_FETCH, OP_LOAD, OP_STORE, OP_BRANCH)
  - the state enum (S_INIT, S_IDLE, S_RD_WAIT, S_WR, S_BR)
- One sub-module, mem_lat_timer: loadable down-counter with RAM_LAT parameter, inputs load/en, output expired. Everything else lives in one FSM plus register file.

Test Plan:
- Reset then start_pc=8'h10, RAM[10]=16'hA5A5, FETCH -> cmd_ready high 1 cycle after reset release; done 2 cycles after accept; ir=16'hA5A5, pc=8'h11.
- STORE addr=8'h20 wdata=16'h1234, then LOAD addr=8'h20 issued in the done cycle -> ram_w_en high exactly 1 cycle; load accepted with no bubble; ld_data=16'h1234 2 cycles later.
- BRANCH cmd_addr=8'hFF, then two FETCHes, RAM[FF]=16'h0001, RAM[00]=16'h0002 -> pc goes FF->00->01; ir=16'h0001 then 16'h0002.
- RAM_LAT=3, LOAD addr=8'h05 (RAM[05]=16'hBEEF), cmd_valid held through the wait with changing cmd_addr -> done exactly 4 cycles after accept; ld_data=16'hBEEF; cmd_ready low during wait; no second accept.
- Assert rst_n=0 in the WR cycle of a STORE -> ram_w_en falls asynchronously; no done; after release state is INIT, then pc=start_pc.
- ADDR_W=10, DATA_W=32, start_pc=10'h3FF, FETCH -> pc wraps to 10'h000; 32-bit ir captured correctly.
